// File: rtl/branch_resolver.sv
// branch_resolver: drives a 2-bit branch predictor and tracks outstanding predictions until execute resolves them
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     branch_valid,
  output logic                     branch_ready,
  output logic                     fetch_pred_valid,
  output logic                     fetch_pred_taken,
  input  logic                     outcome_valid,
  input  logic                     outcome_taken,
  output logic                     outcome_ready,
  output logic                     mispredict,
  output logic                     pred_request,
  output logic                     pred_result,
  output logic                     pred_taken,
  input  logic                     pred_prediction,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic [CNT_W-1:0]         branch_count,
  output logic [CNT_W-1:0]         mispredict_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESOLVE} state_t;
  state_t state, state_next;
  logic [DEPTH-1:0] fifo;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic empty, full, take_branch, take_outcome;
  assign empty = inflight == '0;
  assign full = inflight == (AW+1)'(DEPTH);
  always_ff @(posedge clk) state <= reset ? IDLE : state_next;
  always_comb begin
    state_next = state == REQ ? WAIT :
                 state != IDLE ? IDLE :
                 take_outcome ? RESOLVE :
                 take_branch ? REQ : IDLE;
  end
  // an outcome wins over a new branch when both arrive in the same idle cycle
  always_comb begin
    outcome_ready = state == IDLE && !empty;
    branch_ready = state == IDLE && !full && !(outcome_valid && !empty);
    take_outcome = outcome_valid && outcome_ready;
    take_branch = branch_valid && branch_ready;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_request <= 1'b0;
      pred_result <= 1'b0;
      pred_taken <= 1'b0;
      mispredict <= 1'b0;
      fetch_pred_valid <= 1'b0;
      fetch_pred_taken <= 1'b0;
      fifo <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      inflight <= '0;
      branch_count <= '0;
      mispredict_count <= '0;
    end else begin
      pred_request <= take_branch;
      pred_result <= take_outcome;
      pred_taken <= take_outcome && outcome_taken;
      mispredict <= take_outcome && (fifo[rd_ptr] != outcome_taken);
      fetch_pred_valid <= state == WAIT;
      fetch_pred_taken <= state == WAIT && pred_prediction;
      if (state == WAIT) begin
        fifo[wr_ptr] <= pred_prediction;
        wr_ptr <= wr_ptr + 1'b1;
        inflight <= inflight + 1'b1;
        branch_count <= branch_count + CNT_W'(branch_count != '1);
      end
      if (state == RESOLVE) begin
        rd_ptr <= rd_ptr + 1'b1;
        inflight <= inflight - 1'b1;
        mispredict_count <= mispredict_count + CNT_W'(mispredict && mispredict_count != '1);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed plan plus random traffic against a transaction-level model and a 2-bit predictor
module tb_branch_resolver;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int MAXC = 2**CNT_W - 1;
  logic clk = 0, reset = 1, branch_valid = 0, outcome_valid = 0, outcome_taken = 0;
  logic pred_prediction = 0;
  logic branch_ready, fetch_pred_valid, fetch_pred_taken, outcome_ready, mispredict;
  logic pred_request, pred_result, pred_taken;
  logic [$clog2(DEPTH):0] inflight;
  logic [CNT_W-1:0] branch_count, mispredict_count;
  always #5 clk = ~clk;
  branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .branch_valid(branch_valid), .branch_ready(branch_ready),
    .fetch_pred_valid(fetch_pred_valid), .fetch_pred_taken(fetch_pred_taken),
    .outcome_valid(outcome_valid), .outcome_taken(outcome_taken), .outcome_ready(outcome_ready),
    .mispredict(mispredict), .pred_request(pred_request), .pred_result(pred_result),
    .pred_taken(pred_taken), .pred_prediction(pred_prediction), .inflight(inflight),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );
  // the predictor itself: no reset, powers up strongly taken
  int pctr = 3;
  always @(posedge clk)
    if (pred_request) pred_prediction <= pctr >= 2;
    else if (pred_result) pctr <= pred_taken ? (pctr == 3 ? 3 : pctr + 1) : (pctr == 0 ? 0 : pctr - 1);
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask
  // reference model: queue of predictions plus the cycle at which each pulse is due
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  bit q[$];
  int ref_ctr = 3, br_cnt = 0, mis_cnt = 0, idle_at = 0, req_at = -1, fpv_at = -1, res_at = -1;
  bit fpt, ptk, mis;
  always @(negedge clk) begin : mon
    bit idle, e_br, e_or;
    idle = cyc >= idle_at;
    e_or = idle && q.size() != 0;
    e_br = idle && q.size() < DEPTH && !(outcome_valid && q.size() != 0);
    if (cyc >= 1) begin
      check("branch_ready", branch_ready, e_br);
      check("outcome_ready", outcome_ready, e_or);
      check("pred_request", pred_request, cyc == req_at);
      check("pred_result", pred_result, cyc == res_at);
      check("pred_taken", pred_taken, cyc == res_at && ptk);
      check("mispredict", mispredict, cyc == res_at && mis);
      check("fetch_pred_valid", fetch_pred_valid, cyc == fpv_at);
      check("fetch_pred_taken", fetch_pred_taken, cyc == fpv_at && fpt);
      if (idle) begin
        check("inflight", inflight, q.size());
        check("branch_count", branch_count, br_cnt);
        check("mispredict_count", mispredict_count, mis_cnt);
      end
    end
    if (reset) begin
      q.delete();
      br_cnt = 0; mis_cnt = 0; idle_at = cyc + 1; req_at = -1; fpv_at = -1; res_at = -1;
    end else if (e_or && outcome_valid) begin
      mis = q.pop_front() != outcome_taken;
      ptk = outcome_taken;
      res_at = cyc + 1; idle_at = cyc + 2;
      if (mis && mis_cnt < MAXC) mis_cnt++;
      ref_ctr = outcome_taken ? (ref_ctr == 3 ? 3 : ref_ctr + 1) : (ref_ctr == 0 ? 0 : ref_ctr - 1);
    end else if (e_br && branch_valid) begin
      fpt = ref_ctr >= 2;
      q.push_back(fpt);
      req_at = cyc + 1; fpv_at = cyc + 3; idle_at = cyc + 3;
      if (br_cnt < MAXC) br_cnt++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_branch();
    bit got = 0;
    branch_valid = 1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = branch_ready;
    end
    if (!got) check("branch_timeout", 0, 1);
    tick();
    branch_valid = 0;
  endtask
  task automatic do_outcome(input bit t);
    bit got = 0;
    outcome_valid = 1;
    outcome_taken = t;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = outcome_ready;
    end
    if (!got) check("outcome_timeout", 0, 1);
    tick();
    outcome_valid = 0;
  endtask
  initial begin
    repeat (3) tick();
    reset = 0;
    tick();
    do_branch();
    check("t1_req", pred_request, 1);
    tick(); tick();
    check("t1_fpv", fetch_pred_valid, 1);
    check("t1_fpt", fetch_pred_taken, 1);
    check("t1_inflight", inflight, 1);
    check("t1_bcnt", branch_count, 1);
    do_outcome(0);
    check("t2_result", pred_result, 1);
    check("t2_taken", pred_taken, 0);
    check("t2_mis", mispredict, 1);
    tick();
    check("t2_mcnt", mispredict_count, 1);
    check("t2_inflight", inflight, 0);
    do_branch(); tick(); tick();
    check("t3_fpt1", fetch_pred_taken, 1);
    do_outcome(0);
    check("t3_mis1", mispredict, 1);
    tick();
    do_branch(); tick(); tick();
    check("t3_fpt2", fetch_pred_taken, 0);
    do_outcome(0);
    check("t3_mis2", mispredict, 0);
    tick();
    check("t3_mcnt", mispredict_count, 2);
    branch_valid = 1;
    repeat (16) tick();
    check("t4_full_inflight", inflight, 4);
    check("t4_full_ready", branch_ready, 0);
    do_outcome(1);
    tick();
    check("t4_inflight", inflight, 3);
    check("t4_ready", branch_ready, 1);
    branch_valid = 0;
    repeat (3) begin
      do_outcome(1'($urandom_range(1)));
      tick();
    end
    do_branch(); tick(); tick();
    do_branch(); tick(); tick();
    check("t5_inflight", inflight, 2);
    branch_valid = 1; outcome_valid = 1; outcome_taken = 1;
    tick();
    outcome_valid = 0;
    check("t5_result", pred_result, 1);
    check("t5_noreq", pred_request, 0);
    tick(); tick();
    check("t5_req", pred_request, 1);
    check("t5_nores", pred_result, 0);
    branch_valid = 0;
    tick(); tick();
    do_branch(); tick();
    reset = 1;
    tick();
    reset = 0;
    check("t6_fpv", fetch_pred_valid, 0);
    check("t6_inflight", inflight, 0);
    check("t6_bcnt", branch_count, 0);
    check("t6_mcnt", mispredict_count, 0);
    outcome_valid = 1;
    check("t6_oready", outcome_ready, 0);
    tick();
    check("t6_nores", pred_result, 0);
    outcome_valid = 0;
    repeat (3000) begin
      branch_valid = 1'($urandom_range(1));
      outcome_valid = $urandom_range(2) == 0;
      outcome_taken = 1'($urandom_range(1));
      reset = $urandom_range(59) == 0;
      tick();
    end
    reset = 0; branch_valid = 0; outcome_valid = 0;
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
